// File: rtl/wb_midi_rx.sv
// Generic circular FIFO with same-cycle push/pop.
// Latency: a pushed word is visible at the head one clock after push_vld.
// Backpressure: none upstream; a push into a full FIFO with no pop is dropped and flagged on ovr_pls.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_vld/push_dat write side
//   pop_vld           remove head (ignored when empty)
//   head_dat          current head, 0 when empty
//   count/full/empty  occupancy
//   ovr_pls           one-cycle pulse when a push was dropped
module wb_midi_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_vld,
    output logic [DW-1:0] head_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovr_pls
);

    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop_vld & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_vld & (~full | do_pop);
    assign ovr_pls = push_vld & full & ~do_pop;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// MIDI 8N1 receiver with receive FIFO behind a Wishbone classic slave.
// Latency: byte enters FIFO one clock after stop-bit sample; Wishbone ack one clock after request.
// Backpressure: none on the serial side; bytes arriving with the FIFO full are dropped and set OVR.
//
// Ports:
//   clk_i, rst_n_i    system clock, asynchronous active-low reset
//   rx_i              MIDI serial input, asynchronous, idle high
//   wb_*              Wishbone classic slave (addr 0 DATA, 1 STATUS, 2 CTRL, 3 LEVEL)
//   irq_o             level interrupt: IEN & (NEMPTY | OVR | FERR), registered
module wb_midi_rx #(
    parameter int CLKS_PER_BIT = 384,
    parameter int FIFO_AW      = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [1:0] wb_addr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       irq_o
);

    localparam int               DIV_W    = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_LEVEL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    // ---------------- input conditioning ----------------
    logic rx_s1;
    logic rx_s2;
    logic rx_d;
    logic rx_fall;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall = rx_d & ~rx_s2;

    // ---------------- receiver FSM ----------------
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic             push_vld_q;
    logic             div_zero;

    logic div_load_half;
    logic div_load_full;
    logic div_dec;
    logic bit_clr;
    logic shift_en;
    logic push_en;
    logic ferr_en;

    assign div_zero = (div_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rx_fall) state_nxt = S_START;
            // A high line at mid-start means the edge was a glitch.
            S_START: if (div_zero) state_nxt = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (div_zero && bit_cnt == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (div_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        div_load_half = 1'b0;
        div_load_full = 1'b0;
        div_dec       = 1'b0;
        bit_clr       = 1'b0;
        shift_en      = 1'b0;
        push_en       = 1'b0;
        ferr_en       = 1'b0;
        case (state)
            S_IDLE: begin
                div_load_half = rx_fall;
            end
            S_START: begin
                if (div_zero) begin
                    div_load_full = ~rx_s2;
                    bit_clr       = ~rx_s2;
                end else begin
                    div_dec = 1'b1;
                end
            end
            S_DATA: begin
                if (div_zero) begin
                    shift_en      = 1'b1;
                    div_load_full = 1'b1;
                end else begin
                    div_dec = 1'b1;
                end
            end
            S_STOP: begin
                if (div_zero) begin
                    push_en = rx_s2;
                    ferr_en = ~rx_s2;
                end else begin
                    div_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            push_vld_q <= 1'b0;
        end else begin
            if (div_load_half) begin
                div_cnt <= DIV_HALF;
            end else if (div_load_full) begin
                div_cnt <= DIV_FULL;
            end else if (div_dec) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            // LSB arrives first, so shift in from the top.
            if (shift_en) begin
                shift_q <= {rx_s2, shift_q[7:1]};
            end
            // shift_q is stable until the next frame's data bits, so it
            // can feed the FIFO directly on the following clock.
            push_vld_q <= push_en;
        end
    end

    // ---------------- receive FIFO ----------------
    logic [7:0]       head_dat;
    logic [FIFO_AW:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovr_pls;
    logic             fifo_pop;

    wb_midi_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .push_vld (push_vld_q),
        .push_dat (shift_q),
        .pop_vld  (fifo_pop),
        .head_dat (head_dat),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .ovr_pls  (ovr_pls)
    );

    // ---------------- Wishbone slave ----------------
    logic       wb_req;
    logic       rd_en;
    logic       wr_en;
    logic       ovr_q;
    logic       ferr_q;
    logic       ien_q;
    logic       ovr_clr;
    logic       ferr_clr;
    logic [7:0] rd_mux;
    logic [7:0] level_dat;
    logic       wb_dat_unused;

    assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd_en    = wb_req & ~wb_we_i;
    assign wr_en    = wb_req & wb_we_i;
    assign fifo_pop = rd_en & (wb_addr_i == ADDR_DATA);
    assign ovr_clr  = wr_en & (wb_addr_i == ADDR_STATUS) & wb_dat_i[2];
    assign ferr_clr = wr_en & (wb_addr_i == ADDR_STATUS) & wb_dat_i[3];

    assign wb_dat_unused = ^{wb_dat_i[7:4], wb_dat_i[1]};

    always_comb begin
        level_dat              = '0;
        level_dat[FIFO_AW:0]   = fifo_cnt;
    end

    always_comb begin
        rd_mux = '0;
        case (wb_addr_i)
            ADDR_DATA:   rd_mux = head_dat;
            ADDR_STATUS: rd_mux = {4'b0, ferr_q, ovr_q, fifo_full, ~fifo_empty};
            ADDR_CTRL:   rd_mux = {7'b0, ien_q};
            ADDR_LEVEL:  rd_mux = level_dat;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            ien_q    <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            wb_ack_o <= wb_req;
            wb_dat_o <= rd_en ? rd_mux : 8'h00;
            if (wr_en && wb_addr_i == ADDR_CTRL) begin
                ien_q <= wb_dat_i[0];
            end
            // Set events take priority over a coincident software clear.
            if (ovr_pls) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
            if (ferr_en) begin
                ferr_q <= 1'b1;
            end else if (ferr_clr) begin
                ferr_q <= 1'b0;
            end
            irq_o <= ien_q & (~fifo_empty | ovr_q | ferr_q);
        end
    end

endmodule
